// File: rtl/sram_arbiter_if.sv
// Bundle of channel request/response and SRAM command signals for sram_arbiter.
// The arbiter connects through the slave modport; requesters/SRAM drive the master side.
interface sram_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 1536
);
  logic                       init;
  logic [NUM_CH-1:0]          req;
  logic [NUM_CH-1:0]          we;
  logic [NUM_CH-1:0]          lock;
  logic [NUM_CH*ADDR_W-1:0]   ch_addr;
  logic [NUM_CH*DATA_W-1:0]   ch_wdata;
  logic [NUM_CH-1:0]          ack;
  logic [NUM_CH-1:0]          rvalid;
  logic [DATA_W-1:0]          rdata;
  logic                       read_enable;
  logic                       write_enable;
  logic [ADDR_W-1:0]          address;
  logic [DATA_W-1:0]          write_data;
  logic [DATA_W-1:0]          sram_rdata;

  modport slave (
    input  init, req, we, lock, ch_addr, ch_wdata, sram_rdata,
    output ack, rvalid, rdata, read_enable, write_enable, address, write_data
  );

  modport master (
    output init, req, we, lock, ch_addr, ch_wdata, sram_rdata,
    input  ack, rvalid, rdata, read_enable, write_enable, address, write_data
  );
endinterface

// File: rtl/sram_arbiter.sv
// Multi-channel SRAM arbiter: round-robin or fixed-priority grant with burst lock,
// registered SRAM command and an in-order read-return pipeline.
module sram_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 1536,
  parameter int RD_LAT  = 1,
  parameter int RR_MODE = 1
) (
  input logic          clk,
  input logic          rst,
  sram_arbiter_if.slave bus
);
  localparam int CH_W = $clog2(NUM_CH);
  typedef logic [CH_W-1:0] ch_t;

  logic [NUM_CH-1:0] elig_s;
  logic              grant_s;
  logic              lock_hit_s;
  ch_t               win_s;
  logic [NUM_CH-1:0] ack_s;
  logic [NUM_CH-1:0] rvalid_s;

  ch_t               ptr_r;
  ch_t               lock_ch_r;
  logic              lock_vld_r;
  ch_t               cmd_ch_r;
  logic              read_enable_r;
  logic              write_enable_r;
  logic [ADDR_W-1:0] address_r;
  logic [DATA_W-1:0] write_data_r;
  logic              rd_vld_r [RD_LAT];
  ch_t               rd_ch_r  [RD_LAT];

  function automatic ch_t rr_idx(input ch_t p, input int off);
    int s;
    s = int'(p) + off;
    return (s >= NUM_CH) ? ch_t'(s - NUM_CH) : ch_t'(s);
  endfunction

  // Eligibility: init restricts the grant to channel 0
  always_comb begin
    elig_s = bus.req;
    if (bus.init) begin
      elig_s = bus.req & NUM_CH'(1);
    end else begin
      elig_s = bus.req;
    end
  end

  // Winner selection; loops run high-to-low so the lowest offset is assigned last
  always_comb begin
    grant_s    = 1'b0;
    lock_hit_s = 1'b0;
    win_s      = '0;
    if (lock_vld_r && elig_s[lock_ch_r]) begin
      grant_s    = 1'b1;
      lock_hit_s = 1'b1;
      win_s      = lock_ch_r;
    end else if (RR_MODE != 0) begin
      for (int off = NUM_CH - 1; off >= 0; off--) begin
        grant_s = grant_s | elig_s[rr_idx(ptr_r, off)];
        win_s   = elig_s[rr_idx(ptr_r, off)] ? rr_idx(ptr_r, off) : win_s;
      end
    end else begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        grant_s = grant_s | elig_s[i];
        win_s   = elig_s[i] ? ch_t'(i) : win_s;
      end
    end
  end

  // Combinational grant, forced low while reset is asserted
  always_comb begin
    ack_s = '0;
    if (rst) begin
      ack_s = '0;
    end else if (grant_s) begin
      ack_s[win_s] = 1'b1;
    end else begin
      ack_s = '0;
    end
  end

  // Round-robin pointer and burst-lock memory
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r      <= '0;
      lock_vld_r <= 1'b0;
      lock_ch_r  <= '0;
    end else begin
      lock_vld_r <= grant_s & bus.lock[win_s];
      lock_ch_r  <= win_s;
      if (grant_s && !lock_hit_s && (RR_MODE != 0)) begin
        ptr_r <= (win_s == ch_t'(NUM_CH - 1)) ? '0 : win_s + 1'b1;
      end else begin
        ptr_r <= ptr_r;
      end
    end
  end

  // Registered SRAM command from the winning channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_enable_r  <= 1'b0;
      write_enable_r <= 1'b0;
      address_r      <= '0;
      write_data_r   <= '0;
      cmd_ch_r       <= '0;
    end else if (grant_s) begin
      read_enable_r  <= ~bus.we[win_s];
      write_enable_r <= bus.we[win_s];
      address_r      <= bus.ch_addr[int'(win_s) * ADDR_W +: ADDR_W];
      write_data_r   <= bus.ch_wdata[int'(win_s) * DATA_W +: DATA_W];
      cmd_ch_r       <= win_s;
    end else begin
      read_enable_r  <= 1'b0;
      write_enable_r <= 1'b0;
    end
  end

  // Read-return shift pipeline; reset discards every read in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        rd_vld_r[i] <= 1'b0;
        rd_ch_r[i]  <= '0;
      end
    end else begin
      rd_vld_r[0] <= read_enable_r;
      rd_ch_r[0]  <= cmd_ch_r;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_vld_r[i] <= rd_vld_r[i-1];
        rd_ch_r[i]  <= rd_ch_r[i-1];
      end
    end
  end

  // One-hot read-return strobe from the last pipeline stage
  always_comb begin
    rvalid_s = '0;
    if (rd_vld_r[RD_LAT-1]) begin
      rvalid_s[rd_ch_r[RD_LAT-1]] = 1'b1;
    end else begin
      rvalid_s = '0;
    end
  end

  assign bus.ack          = ack_s;
  assign bus.rvalid       = rvalid_s;
  assign bus.rdata        = bus.sram_rdata;
  assign bus.read_enable  = read_enable_r;
  assign bus.write_enable = write_enable_r;
  assign bus.address      = address_r;
  assign bus.write_data   = write_data_r;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed scoreboard bench for sram_arbiter: a round-robin instance (RD_LAT=2)
// and a fixed-priority instance, with a small SRAM read model.
module tb_sram_arbiter;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  sram_arbiter_if #(.NUM_CH(4), .ADDR_W(19), .DATA_W(32)) rr_if ();
  sram_arbiter_if #(.NUM_CH(4), .ADDR_W(19), .DATA_W(32)) fp_if ();

  sram_arbiter #(.NUM_CH(4), .ADDR_W(19), .DATA_W(32), .RD_LAT(2), .RR_MODE(1)) dut_rr (
    .clk (clk),
    .rst (rst),
    .bus (rr_if.slave)
  );

  sram_arbiter #(.NUM_CH(4), .ADDR_W(19), .DATA_W(32), .RD_LAT(2), .RR_MODE(0)) dut_fp (
    .clk (clk),
    .rst (rst),
    .bus (fp_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [18:0] addr_v [4] = '{19'h00010, 19'h00021, 19'h00123, 19'h00034};
  logic [31:0] wdat_v [4] = '{32'hD000_0000, 32'hD000_0011, 32'hD000_0022, 32'hD000_0033};

  assign rr_if.ch_addr  = {addr_v[3], addr_v[2], addr_v[1], addr_v[0]};
  assign rr_if.ch_wdata = {wdat_v[3], wdat_v[2], wdat_v[1], wdat_v[0]};
  assign fp_if.ch_addr  = {addr_v[3], addr_v[2], addr_v[1], addr_v[0]};
  assign fp_if.ch_wdata = {wdat_v[3], wdat_v[2], wdat_v[1], wdat_v[0]};
  assign fp_if.sram_rdata = 32'h0000_0000;

  function automatic logic [31:0] sram_f(input logic [18:0] a);
    return {13'b0, a} ^ 32'h0000_0B9F;
  endfunction

  // SRAM model: data for the address presented two cycles earlier
  logic [18:0] sram_a0;
  logic [18:0] sram_a1;
  always @(posedge clk) begin
    sram_a0 <= rr_if.address;
    sram_a1 <= sram_a0;
  end
  assign rr_if.sram_rdata = sram_f(sram_a1);

  logic [51:0] cmd_q [$];
  logic [33:0] rd_q  [$];
  logic [51:0] exp_c;
  logic [33:0] exp_r;
  logic [3:0]  exp_oh;
  logic [1:0]  en_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int oh2i(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) return i;
    end
    return 0;
  endfunction

  // Monitor: pops expected commands and read returns whenever the DUT presents one
  always @(negedge clk) begin
    if (!rst) begin
      if (rr_if.read_enable || rr_if.write_enable) begin
        if (cmd_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL cmd_unexpected: got re=%0b we=%0b addr=%0h expected none", rr_if.read_enable,
                   rr_if.write_enable, rr_if.address);
        end else begin
          exp_c = cmd_q.pop_front();
          check("cmd_we", 64'(rr_if.write_enable), 64'(exp_c[51]));
          check("cmd_re", 64'(rr_if.read_enable), 64'(!exp_c[51]));
          check("cmd_addr", 64'(rr_if.address), 64'(exp_c[50:32]));
          check("cmd_wdata", 64'(rr_if.write_data), 64'(exp_c[31:0]));
        end
      end
      if (rr_if.rvalid != 4'b0000) begin
        if (rd_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rd_unexpected: got rvalid=%0b expected none", rr_if.rvalid);
        end else begin
          exp_r  = rd_q.pop_front();
          exp_oh = 4'b0001 << exp_r[33:32];
          check("rd_rvalid", 64'(rr_if.rvalid), 64'(exp_oh));
          check("rd_rdata", 64'(rr_if.rdata), 64'(exp_r[31:0]));
        end
      end
    end
  end

  // One cycle with inputs already applied: check ack/rvalid/enables, record expectations
  task automatic cycle(input logic [3:0] exp_ack, input logic [3:0] exp_rv,
                       input bit push_cmd, input bit push_rd);
    int ch;
    @(negedge clk);
    check("ack", 64'(rr_if.ack), 64'(exp_ack));
    check("rvalid", 64'(rr_if.rvalid), 64'(exp_rv));
    check("cmd_en", 64'({rr_if.read_enable, rr_if.write_enable}), 64'(en_exp));
    if (exp_ack != 4'b0000) begin
      ch = oh2i(exp_ack);
      if (push_cmd) cmd_q.push_back({rr_if.we[ch], addr_v[ch], wdat_v[ch]});
      if (push_rd && !rr_if.we[ch]) rd_q.push_back({2'(ch), sram_f(addr_v[ch])});
      en_exp = rr_if.we[ch] ? 2'b01 : 2'b10;
    end else begin
      en_exp = 2'b00;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_check();
    @(negedge clk);
    check("rst_ack", 64'(rr_if.ack), 64'd0);
    check("rst_rvalid", 64'(rr_if.rvalid), 64'd0);
    check("rst_en", 64'({rr_if.read_enable, rr_if.write_enable}), 64'd0);
    check("rst_addr", 64'(rr_if.address), 64'd0);
    check("rst_wdata", 64'(rr_if.write_data), 64'd0);
    check("rst_fp_ack", 64'(fp_if.ack), 64'd0);
    en_exp = 2'b00;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] rr_seq [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                             4'b0001, 4'b0010, 4'b0100, 4'b1000};

  initial begin
    n_checks = 0;
    n_errors = 0;
    en_exp   = 2'b00;
    rst = 1'b1;
    rr_if.init = 1'b0; rr_if.req = 4'b1111; rr_if.we = 4'b1111; rr_if.lock = 4'b0000;
    fp_if.init = 1'b0; fp_if.req = 4'b1111; fp_if.we = 4'b1111; fp_if.lock = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    reset_check();
    rst = 1'b0;
    fp_if.req = 4'b0000;

    // All four channels writing: strict rotation from ptr 0
    for (int k = 0; k < 8; k++) cycle(rr_seq[k], 4'b0000, 1'b1, 1'b0);

    // Channel 2 read at 0x00123: command next cycle, return two cycles after that
    rr_if.req = 4'b0100; rr_if.we = 4'b0000;
    rd_q.push_back({2'd2, 32'h0000_0ABC});
    cycle(4'b0100, 4'b0000, 1'b1, 1'b0);
    rr_if.req = 4'b0000;
    cycle(4'b0000, 4'b0000, 1'b0, 1'b0);
    cycle(4'b0000, 4'b0000, 1'b0, 1'b0);
    cycle(4'b0000, 4'b0100, 1'b0, 1'b0);
    cycle(4'b0000, 4'b0000, 1'b0, 1'b0);

    // Lock: park ptr on 1, then channel 1 holds the bus while locked
    rr_if.we = 4'b1111; rr_if.req = 4'b0001;
    cycle(4'b0001, 4'b0000, 1'b1, 1'b0);
    rr_if.req = 4'b0011; rr_if.lock = 4'b0010;
    for (int k = 0; k < 4; k++) cycle(4'b0010, 4'b0000, 1'b1, 1'b0);
    // The last locked grant still carries over one cycle; then ptr (2) hands over to 0
    rr_if.lock = 4'b0000;
    cycle(4'b0010, 4'b0000, 1'b1, 1'b0);
    cycle(4'b0001, 4'b0000, 1'b1, 1'b0);

    // init: only channel 0 may win; channel 0 issues a read
    rr_if.init = 1'b1; rr_if.req = 4'b1110; rr_if.we = 4'b1110;
    cycle(4'b0000, 4'b0000, 1'b0, 1'b0);
    rr_if.req = 4'b1111;
    cycle(4'b0001, 4'b0000, 1'b1, 1'b1);
    rr_if.init = 1'b0; rr_if.req = 4'b0000;
    cycle(4'b0000, 4'b0000, 1'b0, 1'b0);
    cycle(4'b0000, 4'b0000, 1'b0, 1'b0);
    cycle(4'b0000, 4'b0001, 1'b0, 1'b0);
    cycle(4'b0000, 4'b0000, 1'b0, 1'b0);

    // Two reads in flight, reset one cycle before the first return
    rr_if.we = 4'b0000; rr_if.req = 4'b0010;
    cycle(4'b0010, 4'b0000, 1'b1, 1'b0);
    rr_if.req = 4'b0100;
    cycle(4'b0100, 4'b0000, 1'b0, 1'b0);
    rst = 1'b1; rr_if.req = 4'b1110; rr_if.we = 4'b1111;
    reset_check();
    rst = 1'b0;
    cycle(4'b0010, 4'b0000, 1'b1, 1'b0);
    rr_if.req = 4'b0000;
    cycle(4'b0000, 4'b0000, 1'b0, 1'b0);
    cycle(4'b0000, 4'b0000, 1'b0, 1'b0);
    cycle(4'b0000, 4'b0000, 1'b0, 1'b0);

    // Fixed priority: channel 2 beats 3 every cycle
    fp_if.req = 4'b1100;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("fp_ack", 64'(fp_if.ack), 64'(4'b0100));
      @(posedge clk);
      #1;
    end
    fp_if.req = 4'b0000;
    repeat (3) @(posedge clk);
    #1;

    check("cmd_q_empty", 64'(cmd_q.size()), 64'd0);
    check("rd_q_empty", 64'(rd_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
